uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ requesters. A round-robin
//   arbiter picks one pending request while the arbiter is idle and the UART
//   is free. It then captures that requester's character, launches it with a
//   one-cycle enable pulse, and waits for the UART busy flag to rise and
//   fall. If busy never rises within START_TIMEOUT cycles, the transfer is
//   abandoned with an error pulse.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   req          per-requester request level, held until granted
//   req_data     requester k's character in bits [k*W +: W]
//   grant        one-hot, one-cycle pulse: request accepted, data captured
//   done         one-hot, one-cycle pulse: granted character fully sent
//   uart_enable  one-cycle start pulse to the UART transmitter
//   uart_data    character to the UART, stable from grant until the next grant
//   uart_busy    UART transmitter busy flag
//   arb_busy     high whenever the arbiter is not idle
//   tx_error     one-cycle pulse when the UART never reports busy after enable
//   last_id      index of the most recent grant
module uart_tx_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int START_TIMEOUT    = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [NUM_REQ-1:0]                  done,
    output logic                                uart_enable,
    output logic [INPUT_DATA_WIDTH-1:0]         uart_data,
    input  logic                                uart_busy,
    output logic                                arb_busy,
    output logic                                tx_error,
    output logic [$clog2(NUM_REQ)-1:0]          last_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                        state;
    logic   [CNT_W-1:0]            cnt;

    logic   [ID_W-1:0]             idx;
    logic   [ID_W-1:0]             win_id;
    logic                          win_vld;
    logic   [INPUT_DATA_WIDTH-1:0] win_data;

    // Round-robin search: start one past the last winner and walk upward with
    // wrap, so the previous winner is checked last.
    always_comb begin
        idx      = '0;
        win_id   = '0;
        win_vld  = 1'b0;
        win_data = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_id) + i) % NUM_REQ);
            if (!win_vld && req[idx]) begin
                win_vld  = 1'b1;
                win_id   = idx;
                win_data = req_data[int'(idx)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
            end
        end
    end

    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            grant       <= '0;
            done        <= '0;
            uart_enable <= 1'b0;
            tx_error    <= 1'b0;
            uart_data   <= '0;
            last_id     <= ID_W'(NUM_REQ - 1);
        end else begin
            // Pulse outputs default low; each state raises at most one.
            grant       <= '0;
            done        <= '0;
            uart_enable <= 1'b0;
            tx_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld && !uart_busy) begin
                        grant     <= NUM_REQ'(1) << win_id;
                        uart_data <= win_data;
                        last_id   <= win_id;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Hold off the start pulse while the UART is still busy.
                    if (!uart_busy) begin
                        uart_enable <= 1'b1;
                        cnt         <= '0;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        // Error pulse lands START_TIMEOUT cycles after enable.
                        tx_error <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        done  <= NUM_REQ'(1) << last_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
